wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter ADDR_W, default 16, Wishbone address width.
REQ-002 Parameter DATA_W, default 32, Wishbone data width.
REQ-003 Parameter TIMEOUT, default 255, ack-wait limit in cycles (used only when WB_CMD_MASTER_TIMEOUT_EN is defined); legal range 1..65535.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 i_clk  input  1  sole clock, rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_cmd_valid  input  1  command request.
REQ-008 o_cmd_ready  output  1  command accepted when valid&ready.
REQ-009 i_cmd_we  input  1  1=write, 0=read.
REQ-010 i_cmd_adr  input  ADDR_W  target address.
REQ-011 i_cmd_data  input  DATA_W  write data.
REQ-012 o_rsp_valid  output  1  response available.
REQ-013 i_rsp_ready  input  1  response consumed when valid&ready.
REQ-014 o_rsp_data  output  DATA_W  read data; 0 for writes or errors.
REQ-015 o_rsp_err  output  1  transaction timed out.
REQ-016 o_wb_cyc, o_wb_stb, o_wb_we  output  1 each  Wishbone classic master controls.
REQ-017 o_wb_adr  output  ADDR_W; o_wb_data  output  DATA_W.
REQ-018 i_wb_ack  input  1; i_wb_data  input  DATA_W  slave response.

Function
REQ-019 The block SHALL be an FSM with states IDLE, BUS, RESP; every output SHALL be registered.
REQ-020 In IDLE, o_cmd_ready SHALL be 1; in BUS and RESP it SHALL be 0.
REQ-021 On accept in IDLE (cycle N), the block SHALL capture we/adr/data and, from cycle N+1, assert o_wb_cyc=o_wb_stb=1 in state BUS.
REQ-022 In BUS, o_wb_we, o_wb_adr and o_wb_data SHALL stay constant; o_wb_data SHALL be 0 for reads.
REQ-023 When i_wb_ack is sampled high in BUS (cycle M), the block SHALL deassert cyc/stb at M+1, enter RESP, and drive o_rsp_valid=1 at M+1.
REQ-024 In that case, o_rsp_data SHALL equal i_wb_data sampled at M for reads, 0 for writes; o_rsp_err SHALL be 0.
REQ-025 i_wb_ack SHALL be ignored in IDLE and RESP.
REQ-026 In RESP, o_rsp_valid, o_rsp_data and o_rsp_err SHALL hold until i_rsp_ready=1; on that cycle the FSM SHALL return to IDLE with o_rsp_valid=0 on the next cycle.
REQ-027 The minimum transaction SHALL be accept to rsp_valid = 2 cycles (ack in first BUS cycle); back-to-back commands SHALL be separated by at least one IDLE cycle.

Reset
REQ-028 Asserting i_rst_n=0 SHALL immediately force state IDLE, cyc=stb=we=0, adr/data=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_cmd_ready=0.
REQ-029 o_cmd_ready SHALL become 1 on the first clock edge after i_rst_n deasserts.
REQ-030 Reset during BUS SHALL abandon the cycle with no response generated.

Configuration
REQ-031 Macro WB_CMD_MASTER_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entering BUS and increment each BUS cycle without ack.
REQ-032 Timeout (defined case): after TIMEOUT BUS cycles without ack, the block SHALL drop cyc/stb, enter RESP with o_rsp_err=1 and o_rsp_data=0.
REQ-033 Ack in the timeout cycle (defined case): ack SHALL take priority over timeout.
REQ-034 Macro not defined: no counter SHALL exist, BUS SHALL wait indefinitely, and o_rsp_err SHALL be tied 0.

Verification
REQ-035 Reset, then write adr=0x0004 data=0x00001234, ack after 3 BUS cycles -> cyc/stb high exactly 3 cycles, we=1, rsp_valid with data=0, err=0.
REQ-036 Read adr=0x0008, slave acks in first BUS cycle with 0xDEADBEEF -> rsp_valid 2 cycles after accept, rsp_data=0xDEADBEEF.
REQ-037 Response held with rsp_ready=0 for 5 cycles, new cmd_valid asserted -> cmd_ready stays 0, rsp stable; accept only after rsp_ready pulse plus IDLE cycle.
REQ-038 TIMEOUT_EN, TIMEOUT=4, no ack -> cyc high 4 cycles, rsp_err=1, rsp_data=0; without macro -> cyc stays high for 100 cycles.
REQ-039 i_rst_n pulled low mid-BUS -> cyc/stb 0 same cycle asynchronously, no rsp_valid after release, cmd_ready=1 one edge later.
REQ-040 Spurious i_wb_ack in IDLE and RESP -> no state change, no rsp_data change.

Source files
------------

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: converts single valid/ready commands into Wishbone classic
// bus cycles and returns one response per command.
//
// Optional feature macro: WB_CMD_MASTER_TIMEOUT_EN
//   defined   -> a 16-bit ack-wait counter ends a BUS cycle after TIMEOUT
//                cycles without ack, returning o_rsp_err=1, o_rsp_data=0.
//   undefined -> BUS waits for ack indefinitely; o_rsp_err is always 0.
//
// Ports
//   i_clk, i_rst_n           clock (rising edge), async active-low reset
//   i_cmd_valid/o_cmd_ready  command handshake; i_cmd_we/adr/data payload
//   o_rsp_valid/i_rsp_ready  response handshake; o_rsp_data, o_rsp_err
//   o_wb_cyc/stb/we/adr/data Wishbone master outputs
//   i_wb_ack, i_wb_data      Wishbone slave response
module wb_cmd_master #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [ADDR_W-1:0] i_cmd_adr,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_adr,
    output logic [DATA_W-1:0] o_wb_data,
    input  logic              i_wb_ack,
    input  logic [DATA_W-1:0] i_wb_data
);

    // Reject an out-of-range ack-wait limit at elaboration.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_cmd_master: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              cmd_ready_nx;
    logic              cyc_nx;
    logic              we_nx;
    logic [ADDR_W-1:0] adr_nx;
    logic [DATA_W-1:0] wdata_nx;
    logic              rsp_valid_nx;
    logic [DATA_W-1:0] rsp_data_nx;
    logic              rsp_err_nx;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] cnt;
    logic [15:0] cnt_nx;
`endif

    // Next-state and next-output logic; every output is a flop fed from here.
    always_comb begin
        state_nx     = state;
        cyc_nx       = o_wb_cyc;
        we_nx        = o_wb_we;
        adr_nx       = o_wb_adr;
        wdata_nx     = o_wb_data;
        rsp_valid_nx = o_rsp_valid;
        rsp_data_nx  = o_rsp_data;
        rsp_err_nx   = o_rsp_err;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        cnt_nx       = cnt;
`endif
        case (state)
            IDLE: begin
                // o_cmd_ready is low on the first cycle after reset, so gate on it.
                if (i_cmd_valid && o_cmd_ready) begin
                    state_nx = BUS;
                    cyc_nx   = 1'b1;
                    we_nx    = i_cmd_we;
                    adr_nx   = i_cmd_adr;
                    wdata_nx = i_cmd_we ? i_cmd_data : '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end
            end
            BUS: begin
                // Ack wins over a timeout landing in the same cycle.
                if (i_wb_ack) begin
                    state_nx     = RESP;
                    cyc_nx       = 1'b0;
                    we_nx        = 1'b0;
                    rsp_valid_nx = 1'b1;
                    rsp_data_nx  = o_wb_we ? '0 : i_wb_data;
                    rsp_err_nx   = 1'b0;
                end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                else if (cnt == TMO_LAST) begin
                    state_nx     = RESP;
                    cyc_nx       = 1'b0;
                    we_nx        = 1'b0;
                    rsp_valid_nx = 1'b1;
                    rsp_data_nx  = '0;
                    rsp_err_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
`endif
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b0;
                    rsp_data_nx  = '0;
                    rsp_err_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        cmd_ready_nx = (state_nx == IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_cmd_ready <= 1'b0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_adr    <= '0;
            o_wb_data   <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            o_cmd_ready <= cmd_ready_nx;
            o_wb_cyc    <= cyc_nx;
            o_wb_stb    <= cyc_nx;
            o_wb_we     <= we_nx;
            o_wb_adr    <= adr_nx;
            o_wb_data   <= wdata_nx;
            o_rsp_valid <= rsp_valid_nx;
            o_rsp_data  <= rsp_data_nx;
            o_rsp_err   <= rsp_err_nx;
        end
    end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    // Ack-wait counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nx;
        end
    end
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed scenarios plus random
// transactions compared against per-transaction expectations.
module tb_wb_cmd_master;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 4;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam int MAX_DLY = TMO;
`else
    localparam int MAX_DLY = 6;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_data;
    logic          wb_ack;
    logic [DW-1:0] wb_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_we    (cmd_we),
        .i_cmd_adr   (cmd_adr),
        .i_cmd_data  (cmd_data),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_wb_cyc    (wb_cyc),
        .o_wb_stb    (wb_stb),
        .o_wb_we     (wb_we),
        .o_wb_adr    (wb_adr),
        .o_wb_data   (wb_data),
        .i_wb_ack    (wb_ack),
        .i_wb_data   (wb_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Idle with ack glitching: nothing may move.
    task automatic idle_spur(input int n);
        for (int i = 0; i < n; i++) begin
            wb_ack   = 1'b1;
            wb_rdata = $urandom;
            step();
            chk("idle_spur_ready", 64'(cmd_ready), 64'd1);
            chk("idle_spur_cyc", 64'(wb_cyc), 64'd0);
            chk("idle_spur_rspv", 64'(rsp_valid), 64'd0);
            chk("idle_spur_rspd", 64'(rsp_data), 64'd0);
        end
        wb_ack = 1'b0;
    endtask

    // One command; expected behaviour is derived from the command itself:
    // cyc/stb high for exactly ack_dly cycles, response = read data or 0.
    task automatic txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                       input int ack_dly, input logic [DW-1:0] rd, input int hold,
                       input bit push, input bit spur);
        logic [DW-1:0] exp_wd;
        logic [DW-1:0] exp_rsp;
        exp_wd  = we ? wd : '0;
        exp_rsp = we ? '0 : rd;
        chk("pre_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_data  = wd;
        step();
        cmd_valid = 1'b0;
        cmd_adr   = AW'($urandom);
        cmd_data  = $urandom;
        cmd_we    = 1'($urandom);
        for (int k = 1; k <= ack_dly; k++) begin
            chk("bus_cyc", 64'(wb_cyc), 64'd1);
            chk("bus_stb", 64'(wb_stb), 64'd1);
            chk("bus_we", 64'(wb_we), 64'(we));
            chk("bus_adr", 64'(wb_adr), 64'(adr));
            chk("bus_data", 64'(wb_data), 64'(exp_wd));
            chk("bus_rspv", 64'(rsp_valid), 64'd0);
            chk("bus_ready", 64'(cmd_ready), 64'd0);
            wb_ack   = (k == ack_dly);
            wb_rdata = (k == ack_dly) ? rd : $urandom;
            step();
        end
        wb_ack   = 1'b0;
        wb_rdata = $urandom;
        chk("rsp_cyc", 64'(wb_cyc), 64'd0);
        chk("rsp_stb", 64'(wb_stb), 64'd0);
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rsp_data", 64'(rsp_data), 64'(exp_rsp));
        chk("rsp_err", 64'(rsp_err), 64'd0);
        chk("rsp_ready_lo", 64'(cmd_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            cmd_valid = push;
            wb_ack    = spur;
            wb_rdata  = $urandom;
            step();
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_data", 64'(rsp_data), 64'(exp_rsp));
            chk("hold_err", 64'(rsp_err), 64'd0);
            chk("hold_ready", 64'(cmd_ready), 64'd0);
            chk("hold_cyc", 64'(wb_cyc), 64'd0);
        end
        wb_ack    = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("done_rspv", 64'(rsp_valid), 64'd0);
        chk("done_ready", 64'(cmd_ready), 64'd1);
        chk("done_cyc", 64'(wb_cyc), 64'd0);
        chk("done_rspd", 64'(rsp_data), 64'd0);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        wb_ack    = 1'b0;
        wb_rdata  = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        chk("rst_cyc", 64'(wb_cyc), 64'd0);
        chk("rst_stb", 64'(wb_stb), 64'd0);
        chk("rst_we", 64'(wb_we), 64'd0);
        chk("rst_adr", 64'(wb_adr), 64'd0);
        chk("rst_data", 64'(wb_data), 64'd0);
        chk("rst_rspv", 64'(rsp_valid), 64'd0);
        chk("rst_rspd", 64'(rsp_data), 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        #10 rst_n = 1'b1;
        #1;
        chk("rel_ready_before_edge", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        chk("rel_ready_after_edge", 64'(cmd_ready), 64'd1);

        idle_spur(2);
        txn(1'b1, 16'h0004, 32'h0000_1234, 3, $urandom, 0, 1'b0, 1'b0);
        txn(1'b0, 16'h0008, $urandom, 1, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        txn(1'b0, 16'h0010, 32'h0, 2, 32'hCAFE_F00D, 5, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            txn(1'($urandom), AW'($urandom), $urandom,
                int'($urandom_range(1, MAX_DLY)), $urandom,
                int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
        end
        idle_spur(3);

        // Reset in the middle of a bus cycle.
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 16'h00A0;
        cmd_data  = 32'h5555_AAAA;
        step();
        cmd_valid = 1'b0;
        chk("mid_cyc_before", 64'(wb_cyc), 64'd1);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", 64'(wb_cyc), 64'd0);
        chk("mid_rst_stb", 64'(wb_stb), 64'd0);
        chk("mid_rst_we", 64'(wb_we), 64'd0);
        chk("mid_rst_adr", 64'(wb_adr), 64'd0);
        chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready0", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("mid_rel_ready1", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            wb_ack = 1'b1;
            step();
            chk("mid_no_rsp", 64'(rsp_valid), 64'd0);
            chk("mid_no_cyc", 64'(wb_cyc), 64'd0);
        end
        wb_ack = 1'b0;

        // Slave never acks.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 16'h0100;
        step();
        cmd_valid = 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        for (int k = 0; k < int'(TMO); k++) begin
            chk("tmo_cyc", 64'(wb_cyc), 64'd1);
            chk("tmo_rspv_lo", 64'(rsp_valid), 64'd0);
            wb_rdata = $urandom;
            step();
        end
        chk("tmo_cyc_drop", 64'(wb_cyc), 64'd0);
        chk("tmo_rspv", 64'(rsp_valid), 64'd1);
        chk("tmo_err", 64'(rsp_err), 64'd1);
        chk("tmo_data", 64'(rsp_data), 64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("tmo_done_ready", 64'(cmd_ready), 64'd1);
        txn(1'b0, 16'h0200, 32'h0, int'(TMO), 32'h1357_9BDF, 1, 1'b0, 1'b0);
`else
        for (int k = 0; k < 100; k++) begin
            chk("wait_cyc", 64'(wb_cyc), 64'd1);
            chk("wait_rspv", 64'(rsp_valid), 64'd0);
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("wait_rst_cyc", 64'(wb_cyc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("wait_rel_ready", 64'(cmd_ready), 64'd1);
        txn(1'b0, 16'h0200, 32'h0, 4, 32'h1357_9BDF, 1, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
